// File: rtl/scc_sound_dac.sv
// SCC sound output stage: tick resampling, volume gain with saturation, boxcar average, 1-bit delta-sigma DAC.
// Optional DC-blocking high-pass on the averaged word when SCC_SOUND_DAC_DCBLOCK_EN is defined.
module scc_sound_dac #(
    parameter int SAMPLE_DIV = 6,
    parameter int AVG_LOG2   = 3
) (
    input  logic        clk21m,
    input  logic        reset,
    input  logic [14:0] wavl_in,
    input  logic [2:0]  vol,
    input  logic        mute,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    output logic        clip_flag,
    output logic        dac_out
);

    logic [7:0]         div_cnt;
    logic               tick;
    logic [3:0]         gain;
    logic signed [17:0] prod;
    logic signed [17:0] half;
    logic               clip_raw;
    logic [15:0]        s_word;
    logic signed [20:0] acc;
    logic signed [20:0] acc_sum;
    logic [5:0]         avg_cnt;
    logic               avg_last;
    logic [15:0]        avg_word;
    logic               avg_valid;
    logic [15:0]        ds;
    logic [16:0]        ds_sum;

    assign tick     = (div_cnt == 8'(SAMPLE_DIV - 1));
    assign avg_last = (avg_cnt == 6'((1 << AVG_LOG2) - 1));

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    always_comb begin
        gain     = {1'b0, vol} + 4'd1;
        prod     = $signed({{3{wavl_in[14]}}, wavl_in}) * $signed({14'd0, gain});
        half     = prod >>> 1;
        // half fits 17 bits; overflow of 16 bits shows as disagreement in the top three bits
        clip_raw = (half[17:15] != 3'b000) && (half[17:15] != 3'b111);
        if (mute)
            s_word = '0;
        else if (clip_raw)
            s_word = half[17] ? 16'h8000 : 16'h7FFF;
        else
            s_word = half[15:0];
        acc_sum  = acc + $signed({{5{s_word[15]}}, s_word});
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            avg_cnt   <= '0;
            avg_word  <= '0;
            avg_valid <= 1'b0;
            clip_flag <= 1'b0;
        end else begin
            avg_valid <= tick && avg_last;
            clip_flag <= tick && clip_raw && !mute;
            if (tick) begin
                if (avg_last) begin
                    avg_word <= 16'(acc_sum >>> AVG_LOG2);
                    acc      <= '0;
                    avg_cnt  <= '0;
                end else begin
                    acc      <= acc_sum;
                    avg_cnt  <= avg_cnt + 6'd1;
                end
            end
        end
    end

`ifdef SCC_SOUND_DAC_DCBLOCK_EN
    logic [15:0] x_prev;
    logic [15:0] y_prev;
    logic [17:0] y_full;
    logic [15:0] y_sat;

    always_comb begin
        // y = x - x_prev + y_prev - (y_prev >>> 8), all terms sign-extended to 18 bits
        y_full = {{2{avg_word[15]}}, avg_word} - {{2{x_prev[15]}}, x_prev}
               + {{2{y_prev[15]}}, y_prev} - {{10{y_prev[15]}}, y_prev[15:8]};
        if ((y_full[17:15] != 3'b000) && (y_full[17:15] != 3'b111))
            y_sat = y_full[17] ? 16'h8000 : 16'h7FFF;
        else
            y_sat = y_full[15:0];
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            x_prev    <= '0;
            y_prev    <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= avg_valid;
            if (avg_valid) begin
                x_prev  <= avg_word;
                y_prev  <= y_sat;
                pcm_out <= y_sat;
            end
        end
    end
`else
    assign pcm_out   = avg_word;
    assign pcm_valid = avg_valid;
`endif

    assign ds_sum = {1'b0, ds} + {1'b0, pcm_out ^ 16'h8000};

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            ds      <= '0;
            dac_out <= 1'b0;
        end else begin
            ds      <= ds_sum[15:0];
            dac_out <= ds_sum[16];
        end
    end

endmodule

// File: tb/tb_scc_sound_dac.sv
// Scoreboard bench for scc_sound_dac: windows push expected PCM words, a monitor pops them on pcm_valid.
module tb_scc_sound_dac;

    logic        clk21m = 1'b0;
    logic        reset  = 1'b1;
    logic [14:0] wavl_in = '0;
    logic [2:0]  vol = '0;
    logic        mute = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        clip_flag;
    logic        dac_out;

    int          checks = 0;
    int          errors = 0;
    int          clip_total = 0;
    logic [15:0] exp_q[$];
    bit          steady = 1'b0;
    logic [15:0] steady_exp = '0;
    logic [15:0] mon_exp;
    int          n;
    int          ones;

    scc_sound_dac #(
        .SAMPLE_DIV(6),
        .AVG_LOG2  (3)
    ) dut (
        .clk21m   (clk21m),
        .reset    (reset),
        .wavl_in  (wavl_in),
        .vol      (vol),
        .mute     (mute),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid),
        .clip_flag(clip_flag),
        .dac_out  (dac_out)
    );

    always #5 clk21m = ~clk21m;

    always @(negedge clk21m)
        if (clip_flag) clip_total++;

    always @(negedge clk21m) begin
        if (!reset && pcm_valid) begin
            checks++;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                if (pcm_out !== mon_exp) begin
                    errors++;
                    $display("FAIL pcm_out actual %h required %h", pcm_out, mon_exp);
                end
            end else if (steady) begin
                if (pcm_out !== steady_exp) begin
                    errors++;
                    $display("FAIL pcm_hold actual %h required %h", pcm_out, steady_exp);
                end
            end else begin
                errors++;
                $display("FAIL unexpected_valid actual pcm_out %h required no pcm_valid", pcm_out);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int start, output int cnt);
        cnt = start;
        while (cnt < 200) begin
            @(negedge clk21m);
            cnt++;
            if (pcm_valid) break;
        end
    endtask

    // Called at the negedge where the previous pcm_valid is seen; spans exactly 8 ticks.
    task automatic run_window(input logic [7:0][14:0] w, input logic [7:0][2:0] v,
                              input logic m, input logic [15:0] exp,
                              input int exp_clip, input bit glitch);
        int base;
        #1;
        base = clip_total;
        mute = m;
        exp_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            wavl_in = w[i];
            vol     = v[i];
            if (glitch) begin
                repeat (2) @(negedge clk21m);
                wavl_in = ~w[i];
                vol     = ~v[i];
                mute    = ~m;
                repeat (2) @(negedge clk21m);
                wavl_in = w[i];
                vol     = v[i];
                mute    = m;
                repeat (2) @(negedge clk21m);
            end else begin
                repeat (6) @(negedge clk21m);
            end
        end
        check("valid_timing", 32'(pcm_valid), 32'd1);
        #1;
        check("clip_count", 32'(clip_total - base), 32'(exp_clip));
    endtask

    initial begin
        exp_q.push_back(16'h0000);
        repeat (3) @(negedge clk21m);
        check("rst_pcm_out", 32'(pcm_out), 32'd0);
        check("rst_pcm_valid", 32'(pcm_valid), 32'd0);
        check("rst_clip", 32'(clip_flag), 32'd0);
        check("rst_dac", 32'(dac_out), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk21m);
            check("dac_alternate", 32'(dac_out), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        wait_valid(10, n);
        check("first_valid_cycle", 32'(n), 32'd48);

        run_window({8{15'h0400}}, {8{3'd1}}, 1'b0, 16'h0400, 0, 1'b0);
        run_window({8{15'h0400}}, {8{3'd7}}, 1'b0, 16'h1000, 0, 1'b1);
        run_window({8{15'h3FFF}}, {8{3'd7}}, 1'b0, 16'h7FFF, 8, 1'b0);
        run_window({8{15'h4000}}, {8{3'd7}}, 1'b0, 16'h8000, 8, 1'b0);
        run_window({8{15'h1000}}, {8{3'd7}}, 1'b1, 16'h0000, 0, 1'b0);
        run_window({4{15'h7FF8, 15'h0008}}, {8{3'd1}}, 1'b0, 16'h0000, 0, 1'b0);
        run_window({8{15'h0003}}, {8{3'd0}}, 1'b0, 16'h0001, 0, 1'b0);
        run_window({8{15'h7FFD}}, {8{3'd0}}, 1'b0, 16'hFFFE, 0, 1'b0);
        run_window({8{15'h0100}}, {{4{3'd3}}, {4{3'd1}}}, 1'b0, 16'h0180, 0, 1'b0);

        #1;
        wavl_in = 15'h1000;
        vol     = 3'd1;
        mute    = 1'b0;
        repeat (20) @(negedge clk21m);
        reset = 1'b1;
        #1;
        check("midrst_pcm_out", 32'(pcm_out), 32'd0);
        check("midrst_pcm_valid", 32'(pcm_valid), 32'd0);
        check("midrst_dac", 32'(dac_out), 32'd0);
        repeat (3) @(negedge clk21m);
        wavl_in = 15'h0200;
        exp_q.push_back(16'h0200);
        reset = 1'b0;
        wait_valid(0, n);
        check("midrst_valid_cycle", 32'(n), 32'd48);

        run_window({8{15'h2000}}, {8{3'd3}}, 1'b0, 16'h4000, 0, 1'b0);
        steady_exp = 16'h4000;
        steady     = 1'b1;
        ones       = 0;
        for (int k = 0; k < 65536; k++) begin
            @(negedge clk21m);
            ones += int'(dac_out);
        end
        checks++;
        if (ones < 49151 || ones > 49153) begin
            errors++;
            $display("FAIL dac_density actual %0d required 49152+-1", ones);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
